// File: rtl/common.sv
// Shared core types: pipeline register payloads, data-bus request/response,
// access sizes and the byte-strobe helper used by the memory stage.
package common;
  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    logic   mem_unsigned;
    msize_t msize;
  } control_t;

  typedef struct packed {
    word_t       pc;
    control_t    ctl;
    logic [4:0]  dst;
    logic        is_bubble;
    word_t       alu_result;
    word_t       store_data;
    logic        csr_write;
    logic [11:0] csr_addr;
    word_t       csr_data;
  } execute_data_t;

  typedef struct packed {
    word_t       pc;
    control_t    ctl;
    logic [4:0]  dst;
    logic        is_bubble;
    word_t       alu_result;
    word_t       mem_result;
    logic        misaligned;
    logic        csr_write;
    logic [11:0] csr_addr;
    word_t       csr_data;
  } memory_data_t;

  typedef struct packed {
    logic       valid;
    word_t      addr;
    msize_t     size;
    logic [7:0] strobe;
    word_t      data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  // Byte-lane mask for an access of the given size, before lane alignment.
  function automatic logic [7:0] sizeMask(input msize_t size);
    logic [7:0] mask;
    case (size)
      MSIZE1:  mask = 8'h01;
      MSIZE2:  mask = 8'h03;
      MSIZE4:  mask = 8'h0F;
      MSIZE8:  mask = 8'hFF;
      default: mask = 8'h00;
    endcase
    return mask;
  endfunction
endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store strobe/data alignment, load byte extraction
// with sign/zero extension, and the natural-alignment check.
module mem_align
  import common::*;
(
  input  logic [2:0] byteOff,
  input  msize_t     size,
  input  logic       isUnsigned,
  input  word_t      storeData,
  input  word_t      loadRaw,
  output logic [7:0] strobe,
  output word_t      wdata,
  output word_t      loadResult,
  output logic       misaligned
);
  word_t shifted_s;

  // Store lane placement and misalignment check.
  always_comb begin
    strobe = sizeMask(size) << byteOff;
    wdata  = storeData << {byteOff, 3'b000};
    case (size)
      MSIZE1:  misaligned = 1'b0;
      MSIZE2:  misaligned = byteOff[0];
      MSIZE4:  misaligned = |byteOff[1:0];
      MSIZE8:  misaligned = |byteOff;
      default: misaligned = 1'b0;
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = loadRaw >> {byteOff, 3'b000};
    case (size)
      MSIZE1: begin
        if (isUnsigned) loadResult = {56'd0, shifted_s[7:0]};
        else            loadResult = {{56{shifted_s[7]}}, shifted_s[7:0]};
      end
      MSIZE2: begin
        if (isUnsigned) loadResult = {48'd0, shifted_s[15:0]};
        else            loadResult = {{48{shifted_s[15]}}, shifted_s[15:0]};
      end
      MSIZE4: begin
        if (isUnsigned) loadResult = {32'd0, shifted_s[31:0]};
        else            loadResult = {{32{shifted_s[31]}}, shifted_s[31:0]};
      end
      MSIZE8:  loadResult = shifted_s;
      default: loadResult = shifted_s;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one data-bus transaction per instruction, stalls
// the pipeline until data_ok, and holds the response until the stage retires.
module mem_stage
  import common::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          Iwait,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          Dwait
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r, nextState_s;
  word_t      holdData_r;
  logic       capture_s, reqValid_s, misaligned_s, isMem_s, access_s;
  logic [7:0] strobe_s;
  word_t      wdata_s, loadResult_s;
  logic       unusedAddrOk_s;

  assign unusedAddrOk_s = dresp.addr_ok;

  mem_align uAlign (
    .byteOff    (dataE.alu_result[2:0]),
    .size       (dataE.ctl.msize),
    .isUnsigned (dataE.ctl.mem_unsigned),
    .storeData  (dataE.store_data),
    .loadRaw    (holdData_r),
    .strobe     (strobe_s),
    .wdata      (wdata_s),
    .loadResult (loadResult_s),
    .misaligned (misaligned_s)
  );

  assign isMem_s  = dataE.ctl.mem_read | dataE.ctl.mem_write;
  assign access_s = !dataE.is_bubble && isMem_s && !misaligned_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= nextState_s;
  end

  // Response hold register, loaded only while a request is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          holdData_r <= 64'd0;
    else if (capture_s) holdData_r <= dresp.data;
    else                holdData_r <= holdData_r;
  end

  // Next-state, request valid and stall.
  always_comb begin
    nextState_s = state_r;
    reqValid_s  = 1'b0;
    Dwait       = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          reqValid_s = 1'b1;
          Dwait      = 1'b1;
          if (dresp.data_ok) begin
            capture_s   = 1'b1;
            nextState_s = DONE;
          end else begin
            nextState_s = BUSY;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      BUSY: begin
        reqValid_s = 1'b1;
        Dwait      = 1'b1;
        if (dresp.data_ok) begin
          capture_s   = 1'b1;
          nextState_s = DONE;
        end else begin
          nextState_s = BUSY;
        end
      end
      DONE: begin
        // A frozen pipeline keeps the same instruction here; never re-issue it.
        if (Iwait) nextState_s = DONE;
        else       nextState_s = IDLE;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Bus request and stage output assembly.
  always_comb begin
    dreq.valid  = reqValid_s;
    dreq.addr   = dataE.alu_result;
    dreq.size   = dataE.ctl.msize;
    dreq.data   = wdata_s;
    if (dataE.ctl.mem_write) dreq.strobe = strobe_s;
    else                     dreq.strobe = 8'h00;

    dataM.pc         = dataE.pc;
    dataM.ctl        = dataE.ctl;
    dataM.dst        = dataE.dst;
    dataM.is_bubble  = dataE.is_bubble | Dwait;
    dataM.alu_result = dataE.alu_result;
    dataM.misaligned = !dataE.is_bubble && isMem_s && misaligned_s;
    dataM.csr_write  = dataE.csr_write;
    dataM.csr_addr   = dataE.csr_addr;
    dataM.csr_data   = dataE.csr_data;
    if ((state_r == DONE) && dataE.ctl.mem_read) dataM.mem_result = loadResult_s;
    else                                         dataM.mem_result = dataE.alu_result;
  end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a bus responder with programmable data_ok
// delay, per-cycle request checks, and a result scoreboard popped on retirement.
module tb_mem_stage;
  import common::*;

  logic          clk;
  logic          reset;
  execute_data_t dataE;
  logic          Iwait;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM;
  logic          Dwait;

  int total = 0;
  int bad   = 0;
  int reqIssued = 0;
  logic prevValid = 1'b0;
  logic [63:0] expQ[$];

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .dataE (dataE),
    .Iwait (Iwait),
    .dreq  (dreq),
    .dresp (dresp),
    .dataM (dataM),
    .Dwait (Dwait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Request counter and retirement scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (dreq.valid && !prevValid) reqIssued++;
    prevValid = dreq.valid;
    if (!reset && !dataE.is_bubble && !dataM.is_bubble && !Iwait) begin
      if (expQ.size() == 0) check("sb_underflow", 64'(expQ.size()), 64'd1);
      else                  check("sb_result", dataM.mem_result, expQ.pop_front());
    end
  end

  task automatic setBubble();
    dataE = '0;
    dataE.is_bubble = 1'b1;
  endtask

  // Present one instruction at posedge+1, answer with data_ok in cycle okCyc
  // (0 = request cycle), hold Iwait for iwCyc cycles starting at data_ok.
  task automatic doMem(input string tag, input logic rd, input logic wr, input logic uns,
                       input msize_t sz, input logic [63:0] addr, input logic [63:0] sdata,
                       input logic [63:0] rdata, input int okCyc, input int iwCyc,
                       input logic [63:0] expRes, input logic [7:0] expStrobe,
                       input logic [63:0] expData, input logic expMis);
    dataE = '0;
    dataE.pc = 64'h0000_0000_8000_1000;
    dataE.ctl.reg_write = rd;
    dataE.ctl.mem_read = rd;
    dataE.ctl.mem_write = wr;
    dataE.ctl.mem_unsigned = uns;
    dataE.ctl.msize = sz;
    dataE.dst = 5'd7;
    dataE.alu_result = addr;
    dataE.store_data = sdata;
    dataE.csr_addr = 12'h305;
    expQ.push_back(expRes);
    Iwait = 1'b0;
    dresp.data_ok = 1'b0;
    dresp.data = rdata;
    if (expMis || !(rd || wr)) begin
      @(negedge clk);
      check({tag, "_valid"}, 64'(dreq.valid), 64'd0);
      check({tag, "_dwait"}, 64'(Dwait), 64'd0);
      check({tag, "_mis"}, 64'(dataM.misaligned), 64'(expMis));
      check({tag, "_dst"}, 64'(dataM.dst), 64'd7);
    end else begin
      for (int cyc = 0; cyc <= okCyc; cyc++) begin
        dresp.data_ok = (cyc == okCyc);
        Iwait = (cyc == okCyc) && (iwCyc > 0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(dreq.valid), 64'd1);
        check({tag, "_dwait"}, 64'(Dwait), 64'd1);
        check({tag, "_bubble"}, 64'(dataM.is_bubble), 64'd1);
        check({tag, "_addr"}, dreq.addr, addr);
        check({tag, "_strobe"}, 64'(dreq.strobe), 64'(expStrobe));
        check({tag, "_data"}, dreq.data, expData);
        @(posedge clk);
        #1;
      end
      dresp.data_ok = 1'b0;
      for (int i = 1; i < iwCyc; i++) begin
        Iwait = 1'b1;
        @(negedge clk);
        check({tag, "_hold_valid"}, 64'(dreq.valid), 64'd0);
        check({tag, "_hold_dwait"}, 64'(Dwait), 64'd0);
        check({tag, "_hold_res"}, dataM.mem_result, expRes);
        @(posedge clk);
        #1;
      end
      Iwait = 1'b0;
      @(negedge clk);
      check({tag, "_done_valid"}, 64'(dreq.valid), 64'd0);
      check({tag, "_done_bubble"}, 64'(dataM.is_bubble), 64'd0);
    end
    @(posedge clk);
    #1;
    setBubble();
  endtask

  initial begin
    int reqBefore;
    reset = 1'b1;
    Iwait = 1'b0;
    dresp = '0;
    setBubble();
    #2;
    check("reset_valid", 64'(dreq.valid), 64'd0);
    check("reset_dwait", 64'(Dwait), 64'd0);
    check("reset_bubble", 64'(dataM.is_bubble), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    doMem("sd", 1'b0, 1'b1, 1'b0, MSIZE8, 64'h8000_0010, 64'h1122334455667788, 64'd0,
          2, 0, 64'h8000_0010, 8'hFF, 64'h1122334455667788, 1'b0);
    doMem("lb", 1'b1, 1'b0, 1'b0, MSIZE1, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000,
          0, 0, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'd0, 1'b0);
    doMem("lbu", 1'b1, 1'b0, 1'b1, MSIZE1, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000,
          1, 0, 64'h0000_0000_0000_0080, 8'h00, 64'd0, 1'b0);
    doMem("sh", 1'b0, 1'b1, 1'b0, MSIZE2, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'd0,
          0, 0, 64'h8000_0006, 8'hC0, 64'hABCD_0000_0000_0000, 1'b0);
    doMem("lw_mis", 1'b1, 1'b0, 1'b0, MSIZE4, 64'h8000_0002, 64'd0, 64'd0,
          0, 0, 64'h8000_0002, 8'h00, 64'd0, 1'b1);
    doMem("lh", 1'b1, 1'b0, 1'b0, MSIZE2, 64'h8000_000A, 64'd0, 64'h0000_0000_F00D_0000,
          1, 0, 64'hFFFF_FFFF_FFFF_F00D, 8'h00, 64'd0, 1'b0);
    doMem("alu", 1'b0, 1'b0, 1'b0, MSIZE8, 64'h0000_0000_0000_1234, 64'd0, 64'd0,
          0, 0, 64'h0000_0000_0000_1234, 8'h00, 64'd0, 1'b0);

    reqBefore = reqIssued;
    doMem("lw_iwait", 1'b1, 1'b0, 1'b0, MSIZE4, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_1234_5678,
          0, 4, 64'hFFFF_FFFF_DEAD_BEEF, 8'h00, 64'd0, 1'b0);
    check("iwait_one_req", 64'(reqIssued - reqBefore), 64'd1);

    // Reset while BUSY: request drops immediately, late data_ok is ignored.
    dataE = '0;
    dataE.ctl.mem_read = 1'b1;
    dataE.ctl.msize = MSIZE8;
    dataE.alu_result = 64'h8000_0020;
    dresp.data_ok = 1'b0;
    @(negedge clk);
    check("rst_issue_valid", 64'(dreq.valid), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy_valid", 64'(dreq.valid), 64'd1);
    #2;
    reset = 1'b1;
    setBubble();
    #1;
    check("rst_mid_valid", 64'(dreq.valid), 64'd0);
    check("rst_mid_dwait", 64'(Dwait), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    dresp.data_ok = 1'b1;
    dresp.data = 64'h5555_5555_5555_5555;
    @(negedge clk);
    check("late_ok_valid", 64'(dreq.valid), 64'd0);
    check("late_ok_bubble", 64'(dataM.is_bubble), 64'd1);
    @(posedge clk);
    #1;
    dresp.data_ok = 1'b0;
    doMem("ld_after_rst", 1'b1, 1'b0, 1'b0, MSIZE8, 64'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF,
          1, 0, 64'h0123_4567_89AB_CDEF, 8'h00, 64'd0, 1'b0);

    repeat (2) @(posedge clk);
    check("sb_leftover", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage core. It consumes `execute_data_t` from the execute/memory pipeline register and issues at most one data-bus transaction per instruction. It aligns store data and strobes, extracts and extends load data, and produces `memory_data_t` for the memory/writeback register. While a transaction is outstanding it drives `Dwait`, which freezes the upstream pipeline registers so the same instruction is re-presented.

## Interface
No parameters; XLEN=64 and all widths come from `common`.
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high
- `dataE`  in  execute_data_t  instruction from the E/M register (`pc`, `ctl`, `dst`, `is_bubble`, `alu_result`, `store_data`, csr fields)
- `Iwait`  in  1  fetch-side stall; pipeline frozen this cycle
- `dreq`  out  dbus_req_t  `valid`, `addr[63:0]`, `size`, `strobe[7:0]`, `data[63:0]`
- `dresp`  in  dbus_resp_t  `addr_ok`, `data_ok`, `data[63:0]`
- `dataM`  out  memory_data_t  `dataE` fields plus `mem_result[63:0]`, `misaligned`
- `Dwait`  out  1  stage stalled on the data bus

## Operation
- Access needed: `!dataE.is_bubble && (ctl.mem_read || ctl.mem_write) && !misaligned`.
- `misaligned`: `alu_result` is not a multiple of the size given by `ctl.msize` (1/2/4/8 bytes). A misaligned instruction issues no request, sets `dataM.misaligned=1`, and gives `Dwait=0`.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
  - IDLE, access needed: `dreq.valid=1`, `Dwait=1`. On `data_ok` go to DONE and capture the data. Otherwise go to BUSY.
  - BUSY: `dreq.valid=1` with all fields stable. `Dwait=1`. On `data_ok`, capture the data and go to DONE.
  - DONE: `dreq.valid=0`, `Dwait=0`, `mem_result` comes from the hold register. If `Iwait=0`, go to IDLE because the instruction retires from the stage. If `Iwait=1`, stay in DONE and do not re-issue.
  - IDLE, no access: pass-through, `Dwait=0`, `dreq.valid=0`.
- Store:
  - `addr = alu_result`.
  - `strobe` = size mask (0x01/0x03/0x0F/0xFF) shifted left by `addr[2:0]`.
  - `data = store_data << (8*addr[2:0])`.
- Load:
  - Extract the bytes starting at `addr[2:0]` from the captured data.
  - Sign-extend, or zero-extend when `ctl.mem_unsigned`, to 64 bits.
  - Loads drive `strobe=0`.
- Non-memory instruction: `mem_result = alu_result`.
- `dataM.is_bubble = dataE.is_bubble | Dwait`.
- `dataM.dst` and the csr fields are copied unchanged.
- `addr_ok` is ignored. A transaction completes only on `data_ok`.

## Timing
- Reset (asynchronous): state goes to IDLE and the hold register clears to 0, immediately and without waiting for a clock edge.
  - As a result `dreq.valid=0` at once.
  - `Dwait` follows `dataE`.
- Reset mid-BUSY abandons the transaction. Any `data_ok` arriving in IDLE with no new request is ignored.
- Latency: with `data_ok` in the request cycle, the load result is on `dataM` one cycle later. With `data_ok` after N cycles, the result appears N+1 cycles after the request.
- `Dwait` is combinational from state and `dataE`. The `dreq` fields are combinational from `dataE`, which the E/M register holds constant while `Dwait=1`.
- If `Iwait` and `data_ok` are both high in the same cycle, the data is captured and the stage holds in DONE until `Iwait` falls.
- Back-to-back memory instructions: DONE goes to IDLE, and the next request is issued in the cycle after the one where DONE saw `Iwait=0`.

## Structure
- `common` gains `memory_data_t` and `msize_t` (MSIZE1/2/4/8); `dbus_req_t`/`dbus_resp_t` stay in `common`.
- The FSM state enum is local to `mem_stage`.
- One sub-module, `mem_align`, is combinational: store strobe/data shifting, load extraction/extension, and the misalignment check.

## Test plan
- Store doubleword to addr 0x8000_0010, data 0x1122334455667788, `data_ok` on 3rd cycle → `Dwait` high 3 cycles, strobe 0xFF, `dreq` stable throughout, `dataM.is_bubble=0` on the 4th cycle.
- Load byte at 0x8000_0003, response data 0x00000000_80000000, signed → `mem_result=0xFFFF_FFFF_FFFF_FF80`. The same case with `mem_unsigned` → `0x80`.
- Store halfword at 0x…6 with store_data 0xABCD → strobe 0xC0, `dreq.data[63:48]=0xABCD`.
- Load word at 0x…2 → no `dreq.valid`, `Dwait=0`, `misaligned=1`.
- `data_ok` arriving with `Iwait=1` held 4 cycles → stays in DONE, exactly one request issued, result stable until `Iwait` falls.
- Assert `reset` during BUSY → `dreq.valid=0` the same cycle. A late `data_ok` is ignored and the next load issues normally.
